// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, controller states
// and instruction field positions.
package alu_seq_ctrl_pkg;

  localparam int unsigned INSTR_W  = 9;
  localparam int unsigned OP_MSB   = 8;
  localparam int unsigned OP_LSB   = 5;
  localparam int unsigned T_BIT    = 4;
  localparam int unsigned IMMI_MSB = 4;
  localparam int unsigned RS_MSB   = 3;

  typedef enum logic [3:0] {
    kADD = 4'h0,
    kSUB = 4'h1,
    kAND = 4'h2,
    kOR  = 4'h3,
    kXOR = 4'h4,
    kSHL = 4'h5,
    kSHR = 4'h6,
    kNOT = 4'h7,
    kGST = 4'h8,
    kLRS = 4'h9,
    kACC = 4'hA,
    kBRC = 4'hB,
    kHLT = 4'hF
  } op_mne;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decode: ALU control fields, write-back target and
// branch/halt classification.
module alu_seq_decode
  import alu_seq_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [3:0]         o_alu_op,
  output logic               o_alu_t,
  output logic [4:0]         o_alu_immi,
  output logic [3:0]         o_alu_immx,
  output logic [3:0]         o_rf_waddr,
  output logic               o_wb_en,
  output logic               o_is_halt,
  output logic               o_is_branch
);

  logic [3:0] w_op;
  logic [3:0] w_rs;
  logic       w_t;

  always_comb begin
    w_op        = i_instr[OP_MSB:OP_LSB];
    w_rs        = i_instr[RS_MSB:0];
    w_t         = i_instr[T_BIT];
    o_alu_op    = w_op;
    o_alu_t     = w_t;
    o_alu_immi  = i_instr[IMMI_MSB:0];
    o_alu_immx  = w_rs;
    o_rf_waddr  = '0;
    o_wb_en     = 1'b0;
    o_is_halt   = 1'b0;
    o_is_branch = 1'b0;
    case (w_op)
      kADD, kSUB, kAND, kOR, kXOR, kSHL, kSHR, kNOT: o_wb_en = 1'b1;
      kGST: begin
        o_wb_en = 1'b1;
        if (w_t) o_rf_waddr = w_rs;
      end
      kLRS: begin
        o_wb_en    = 1'b1;
        o_rf_waddr = w_rs;
      end
      // I-format: bit 4 belongs to the immediate, so T is forced low
      kACC: begin
        o_wb_en = 1'b1;
        o_alu_t = 1'b0;
      end
      kBRC: begin
        o_is_branch = 1'b1;
        o_alu_t     = 1'b0;
      end
      kHLT:    o_is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle FETCH/EXEC sequencer for the 8-bit accumulator datapath with a
// START/ACK run handshake and an instruction-count watchdog.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned      PC_W      = 8,
  parameter logic [PC_W-1:0]  START_PC  = '0,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] MAX_INSTR = CNT_W'(16'hFFFF)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  output logic               ACK,
  output logic               TIMEOUT,
  output logic [PC_W-1:0]    IMEM_ADDR,
  input  logic [INSTR_W-1:0] IMEM_DATA,
  output logic [3:0]         RF_RADDR,
  output logic [3:0]         RF_WADDR,
  output logic               RF_WE,
  output logic [3:0]         ALU_OP,
  output logic               ALU_T,
  output logic [4:0]         ALU_IMMI,
  output logic [3:0]         ALU_IMMX,
  input  logic [3:0]         ALU_BOFFSET,
  input  logic               ALU_BSIGN,
  output logic [CNT_W-1:0]   INSTR_CNT
);

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    w_boff;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_timeout;
  logic               w_wdog;
  logic               w_wb_en;
  logic               w_is_halt;
  logic               w_is_branch;

  alu_seq_decode u_decode (
    .i_instr     (r_instr),
    .o_alu_op    (ALU_OP),
    .o_alu_t     (ALU_T),
    .o_alu_immi  (ALU_IMMI),
    .o_alu_immx  (ALU_IMMX),
    .o_rf_waddr  (RF_WADDR),
    .o_wb_en     (w_wb_en),
    .o_is_halt   (w_is_halt),
    .o_is_branch (w_is_branch)
  );

  always_comb begin
    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_wdog    = (w_cnt_inc >= MAX_INSTR);
    w_boff    = PC_W'(ALU_BOFFSET);
    if (w_is_branch) begin
      w_pc_nxt = ALU_BSIGN ? (r_pc - w_boff) : (r_pc + w_boff);
    end else begin
      w_pc_nxt = r_pc + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ACK         = 1'b0;
    RF_WE       = 1'b0;
    case (r_state)
      IDLE:  if (START) w_state_nxt = FETCH;
      FETCH: w_state_nxt = EXEC;
      EXEC: begin
        RF_WE       = w_wb_en;
        w_state_nxt = (w_is_halt || w_wdog) ? DONE : FETCH;
      end
      DONE: begin
        ACK = 1'b1;
        if (!START) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_pc      <= START_PC;
      r_cnt     <= '0;
      r_instr   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_pc      <= START_PC;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
          end
        end
        FETCH: r_instr <= IMEM_DATA;
        EXEC: begin
          r_cnt <= w_cnt_inc;
          if (!w_is_halt) r_pc <= w_pc_nxt;
          if (w_wdog) r_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign IMEM_ADDR = r_pc;
  assign RF_RADDR  = r_instr[RS_MSB:0];
  assign TIMEOUT   = r_timeout;
  assign INSTR_CNT = r_cnt;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: shared ROM, simple branch-resolving ALU model,
// one default instance and one with a small watchdog limit.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       start_a, start_b;
  logic [8:0] rom [256];
  logic [7:0] tb_r0;

  always #5 CLK = ~CLK;

  // instance A (default watchdog)
  logic        ack_a, tmo_a, we_a, t_a, bsign_a;
  logic [7:0]  addr_a;
  logic [8:0]  data_a;
  logic [3:0]  raddr_a, waddr_a, op_a, immx_a, boff_a;
  logic [4:0]  immi_a;
  logic [15:0] cnt_a;

  // instance B (watchdog limit 4)
  logic        ack_b, tmo_b, we_b, t_b, bsign_b;
  logic [7:0]  addr_b;
  logic [8:0]  data_b;
  logic [3:0]  raddr_b, waddr_b, op_b, immx_b, boff_b;
  logic [4:0]  immi_b;
  logic [15:0] cnt_b;

  assign data_a  = rom[addr_a];
  assign data_b  = rom[addr_b];
  assign boff_a  = (tb_r0 == 8'd0) ? immi_a[3:0] : 4'd1;
  assign bsign_a = (tb_r0 == 8'd0) ? immi_a[4]   : 1'b0;
  assign boff_b  = (tb_r0 == 8'd0) ? immi_b[3:0] : 4'd1;
  assign bsign_b = (tb_r0 == 8'd0) ? immi_b[4]   : 1'b0;

  alu_seq_ctrl u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(start_a), .ACK(ack_a), .TIMEOUT(tmo_a),
    .IMEM_ADDR(addr_a), .IMEM_DATA(data_a), .RF_RADDR(raddr_a), .RF_WADDR(waddr_a),
    .RF_WE(we_a), .ALU_OP(op_a), .ALU_T(t_a), .ALU_IMMI(immi_a), .ALU_IMMX(immx_a),
    .ALU_BOFFSET(boff_a), .ALU_BSIGN(bsign_a), .INSTR_CNT(cnt_a)
  );

  alu_seq_ctrl #(.MAX_INSTR(16'd4)) u_wdg (
    .CLK(CLK), .RESET_N(RESET_N), .START(start_b), .ACK(ack_b), .TIMEOUT(tmo_b),
    .IMEM_ADDR(addr_b), .IMEM_DATA(data_b), .RF_RADDR(raddr_b), .RF_WADDR(waddr_b),
    .RF_WE(we_b), .ALU_OP(op_b), .ALU_T(t_b), .ALU_IMMI(immi_b), .ALU_IMMX(immx_b),
    .ALU_BOFFSET(boff_b), .ALU_BSIGN(bsign_b), .INSTR_CNT(cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [4:0] lo);
    return {op, lo};
  endfunction

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  // per-instruction trace of a run on instance A
  logic [7:0] pc_tr   [64];
  logic       we_tr   [64];
  logic [3:0] wa_tr   [64];
  logic [3:0] op_tr   [64];
  logic [4:0] immi_tr [64];
  int         run_cycles;

  // Called at a negedge with A idle; returns at the negedge where ACK is seen.
  task automatic run_a(input int limit);
    run_cycles = 0;
    start_a    = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(negedge CLK);
      run_cycles = k + 1;
      if (ack_a) break;
      if (k < 128) begin
        if (k % 2 == 0) begin
          pc_tr[k/2] = addr_a;
        end else begin
          we_tr[k/2]   = we_a;
          wa_tr[k/2]   = waddr_a;
          op_tr[k/2]   = op_a;
          immi_tr[k/2] = immi_a;
        end
      end
    end
    chk("run_ack", 32'(ack_a), 32'd1);
  endtask

  task automatic end_run_a;
    start_a = 1'b0;
    @(negedge CLK);
    chk("ack_drop", 32'(ack_a), 32'd0);
  endtask

  int  cyc_b;
  logic last_we_b;

  initial begin
    RESET_N = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tb_r0   = 8'd0;
    fill_rom(mk(kHLT, 5'd0));
    repeat (2) @(negedge CLK);
    chk("rst_ack",  32'(ack_a),  32'd0);
    chk("rst_we",   32'(we_a),   32'd0);
    chk("rst_pc",   32'(addr_a), 32'd0);
    chk("rst_cnt",  32'(cnt_a),  32'd0);
    chk("rst_tmo",  32'(tmo_a),  32'd0);
    chk("rst_op",   32'(op_a),   32'd0);
    chk("rst_immi", 32'(immi_a), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // kACC imm=5 then kHLT
    fill_rom(mk(kHLT, 5'd0));
    rom[0] = mk(kACC, 5'd5);
    run_a(20);
    chk("acc_cycles", 32'(run_cycles), 32'd5);
    chk("acc_op",     32'(op_tr[0]),   32'(kACC));
    chk("acc_we",     32'(we_tr[0]),   32'd1);
    chk("acc_waddr",  32'(wa_tr[0]),   32'd0);
    chk("acc_immi",   32'(immi_tr[0]), 32'd5);
    chk("hlt_we",     32'(we_tr[1]),   32'd0);
    chk("acc_cnt",    32'(cnt_a),      32'd2);
    chk("hlt_pc",     32'(addr_a),     32'd1);
    chk("acc_tmo",    32'(tmo_a),      32'd0);
    end_run_a();

    // branches taken: 0 -> 10 -> 7 (backward 3)
    tb_r0 = 8'd0;
    fill_rom(mk(kHLT, 5'd0));
    rom[0]  = mk(kBRC, 5'b0_1010);
    rom[10] = mk(kBRC, 5'b1_0011);
    run_a(40);
    chk("brc_pc10",  32'(pc_tr[1]), 32'd10);
    chk("brc_pc7",   32'(pc_tr[2]), 32'd7);
    chk("brc_we",    32'(we_tr[1]), 32'd0);
    chk("brc_cnt",   32'(cnt_a),    32'd3);
    end_run_a();

    // branch not taken (r0 != 0): PC10 -> 11
    tb_r0 = 8'd3;
    fill_rom(mk(kHLT, 5'd0));
    for (int i = 0; i < 10; i++) rom[i] = mk(kADD, 5'd1);
    rom[10] = mk(kBRC, 5'b1_0011);
    run_a(60);
    chk("nt_pc10", 32'(pc_tr[10]), 32'd10);
    chk("nt_pc11", 32'(pc_tr[11]), 32'd11);
    chk("nt_cnt",  32'(cnt_a),     32'd12);
    end_run_a();

    // wrap both directions: 0 -> 254 -> 2
    tb_r0 = 8'd0;
    fill_rom(mk(kHLT, 5'd0));
    rom[0]   = mk(kBRC, 5'b1_0010);
    rom[254] = mk(kBRC, 5'b0_0100);
    run_a(40);
    chk("wrap_back", 32'(pc_tr[1]), 32'd254);
    chk("wrap_fwd",  32'(pc_tr[2]), 32'd2);
    chk("wrap_cnt",  32'(cnt_a),    32'd3);
    end_run_a();

    // write-back destinations and undefined opcode
    fill_rom(mk(kHLT, 5'd0));
    rom[0] = mk(kGST, 5'b1_0110);
    rom[1] = mk(kGST, 5'b0_0110);
    rom[2] = mk(kLRS, 5'b0_0011);
    rom[3] = mk(4'hC, 5'b1_0101);
    run_a(40);
    chk("gst1_waddr", 32'(wa_tr[0]), 32'd6);
    chk("gst1_we",    32'(we_tr[0]), 32'd1);
    chk("gst0_waddr", 32'(wa_tr[1]), 32'd0);
    chk("gst0_we",    32'(we_tr[1]), 32'd1);
    chk("lrs_waddr",  32'(wa_tr[2]), 32'd3);
    chk("undef_we",   32'(we_tr[3]), 32'd0);
    chk("undef_pc",   32'(pc_tr[4]), 32'd4);
    chk("wb_cnt",     32'(cnt_a),    32'd5);
    end_run_a();

    // reset during EXEC of kADD at PC 5
    fill_rom(mk(kHLT, 5'd0));
    rom[0] = mk(kBRC, 5'b0_0101);
    rom[5] = mk(kADD, 5'b0_0010);
    start_a = 1'b1;
    repeat (4) @(negedge CLK);
    chk("mid_we",  32'(we_a),   32'd1);
    chk("mid_pc",  32'(addr_a), 32'd5);
    RESET_N = 1'b0;
    #1;
    chk("arst_we",  32'(we_a),   32'd0);
    chk("arst_pc",  32'(addr_a), 32'd0);
    chk("arst_ack", 32'(ack_a),  32'd0);
    chk("arst_cnt", 32'(cnt_a),  32'd0);
    start_a = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_pc",  32'(addr_a), 32'd0);
    chk("idle_cnt", 32'(cnt_a),  32'd0);
    chk("idle_we",  32'(we_a),   32'd0);

    // watchdog on instance B: endless straight-line kADD
    fill_rom(mk(kADD, 5'd0));
    cyc_b     = 0;
    last_we_b = 1'b0;
    start_b   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      cyc_b = k + 1;
      if (ack_b) break;
      if (k % 2 == 1) last_we_b = we_b;
    end
    chk("wd_ack",     32'(ack_b),     32'd1);
    chk("wd_cycles",  32'(cyc_b),     32'd9);
    chk("wd_tmo",     32'(tmo_b),     32'd1);
    chk("wd_cnt",     32'(cnt_b),     32'd4);
    chk("wd_last_we", 32'(last_we_b), 32'd1);
    chk("wd_pc",      32'(addr_b),    32'd4);
    repeat (3) @(negedge CLK);
    chk("wd_hold_ack", 32'(ack_b), 32'd1);
    start_b = 1'b0;
    @(negedge CLK);
    chk("wd_idle_ack", 32'(ack_b), 32'd0);
    fill_rom(mk(kHLT, 5'd0));
    start_b = 1'b1;
    @(negedge CLK);
    chk("wd_tmo_clr", 32'(tmo_b), 32'd0);
    repeat (2) @(negedge CLK);
    chk("wd2_ack", 32'(ack_b), 32'd1);
    chk("wd2_tmo", 32'(tmo_b), 32'd0);
    chk("wd2_cnt", 32'(cnt_b), 32'd1);
    start_b = 1'b0;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
